// File: rtl/syncfifo_rd_stream.sv
// syncfifo_rd_stream: drains a syncfifo read port into a valid/ready stream
// through a two-entry output buffer. It handles both standard-latency and
// FWFT FIFO configurations and never reads more words than it can hold.
module syncfifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter bit FWFT_EN    = 1'b0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  beat_cnt
);

  // Buffer storage: buf_head is the stream head, buf_tail is the second entry.
  logic [DATA_WIDTH-1:0] buf_head;
  logic [DATA_WIDTH-1:0] buf_tail;
  logic [1:0]            buf_cnt;
  logic                  inflight;

  logic                  pop;
  logic                  capture;
  logic [2:0]            occ_after_pop;
  logic [1:0]            base_cnt;
  logic [DATA_WIDTH-1:0] head_next;
  logic [DATA_WIDTH-1:0] tail_next;
  logic [1:0]            cnt_next;
  logic                  inflight_next;

  // Read decision, capture decision and next buffer contents for this cycle.
  always_comb begin
    pop           = m_valid && m_ready;
    occ_after_pop = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    fifo_rd_en    = !rst && !fifo_empty && !flush && (occ_after_pop < 3'd2);

    if (FWFT_EN) begin
      capture = fifo_rd_en;
    end else begin
      capture = inflight && !flush;
    end

    base_cnt  = buf_cnt - {1'b0, pop};
    head_next = buf_head;
    tail_next = buf_tail;
    if (pop) begin
      head_next = buf_tail;
    end
    if (capture) begin
      if (base_cnt == 2'd0) begin
        head_next = fifo_dout;
      end else begin
        tail_next = fifo_dout;
      end
    end

    if (flush) begin
      cnt_next = 2'd0;
    end else begin
      cnt_next = base_cnt + {1'b0, capture};
    end

    if (FWFT_EN) begin
      inflight_next = 1'b0;
    end else begin
      inflight_next = fifo_rd_en;
    end
  end

  // Buffer, occupancy, in-flight flag and registered valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_head <= '0;
      buf_tail <= '0;
      buf_cnt  <= 2'd0;
      inflight <= 1'b0;
      m_valid  <= 1'b0;
    end else begin
      buf_head <= head_next;
      buf_tail <= tail_next;
      buf_cnt  <= cnt_next;
      inflight <= inflight_next;
      m_valid  <= (cnt_next != 2'd0);
    end
  end

  // Handshake counter, wraps naturally and ignores flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= beat_cnt + CNT_WIDTH'(1);
    end
  end

  assign m_data = buf_head;

endmodule

// File: tb/tb_syncfifo_rd_stream.sv
// tb_syncfifo_rd_stream: directed test of the read adapter against simple
// behavioral FIFO models, one standard-latency and one FWFT instance.
module tb_syncfifo_rd_stream;

  logic clk = 1'b0;
  logic rst;

  // Clock generation, 10 time-unit period.
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Standard-latency FIFO model feeding dut0.
  logic [7:0] mem0 [256];
  int         wptr0 = 0;
  int         rptr0 = 0;
  logic [7:0] dout0;
  logic       empty0;
  logic       rd0, valid0, ready0, flush0;
  logic [7:0] data0;
  logic [15:0] beat0;

  // FWFT FIFO model feeding dut1.
  logic [7:0] mem1 [256];
  int         wptr1 = 0;
  int         rptr1 = 0;
  logic [7:0] dout1;
  logic       empty1;
  logic       rd1, valid1, ready1;
  logic       flush1 = 1'b0;
  logic [7:0] data1;
  logic [3:0] beat1;

  assign empty0 = (wptr0 == rptr0);
  assign empty1 = (wptr1 == rptr1);
  assign dout1  = mem1[rptr1[7:0]];

  // Standard FIFO read port: data appears the cycle after the read strobe.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr0 <= wptr0;
      dout0 <= 8'd0;
    end else if (rd0) begin
      dout0 <= mem0[rptr0[7:0]];
      rptr0 <= rptr0 + 1;
    end
  end

  // FWFT FIFO read port: head word always visible, strobe advances it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr1 <= wptr1;
    end else if (rd1) begin
      rptr1 <= rptr1 + 1;
    end
  end

  int rd0_count  = 0;
  int viol_empty = 0;
  int viol_occ   = 0;

  // Protocol watch: read strobes, reads while empty, buffer occupancy bound.
  always @(posedge clk) begin
    if (rd0) rd0_count <= rd0_count + 1;
    if ((rd0 && empty0) || (rd1 && empty1)) viol_empty <= viol_empty + 1;
    if (dut0.buf_cnt + dut0.inflight > 2) viol_occ <= viol_occ + 1;
  end

  syncfifo_rd_stream #(.DATA_WIDTH(8), .FWFT_EN(1'b0), .CNT_WIDTH(16)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .fifo_dout  (dout0),
    .fifo_empty (empty0),
    .fifo_rd_en (rd0),
    .m_data     (data0),
    .m_valid    (valid0),
    .m_ready    (ready0),
    .flush      (flush0),
    .beat_cnt   (beat0)
  );

  syncfifo_rd_stream #(.DATA_WIDTH(8), .FWFT_EN(1'b1), .CNT_WIDTH(4)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .fifo_dout  (dout1),
    .fifo_empty (empty1),
    .fifo_rd_en (rd1),
    .m_data     (data1),
    .m_valid    (valid1),
    .m_ready    (ready1),
    .flush      (flush1),
    .beat_cnt   (beat1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int which, input int lo, input int hi);
    for (int v = lo; v <= hi; v++) begin
      if (which == 0) begin
        mem0[wptr0[7:0]] = 8'(v);
        wptr0++;
      end else begin
        mem1[wptr1[7:0]] = 8'(v);
        wptr1++;
      end
    end
  endtask

  // Consume dut0 words lo..hi with m_ready held high; stops on the
  // negedge of the cycle in which the last expected word is popped.
  task automatic collect0(input string tag, input int lo, input int hi);
    int exp_v;
    exp_v = lo;
    for (int c = 0; c < 60 && exp_v <= hi; c++) begin
      if (valid0) begin
        checkOutput(tag, data0, exp_v);
        exp_v++;
      end
      if (exp_v <= hi) @(negedge clk);
    end
    checkOutput({tag, " count"}, exp_v, hi + 1);
  endtask

  initial begin
    int exp_v;
    ready0 = 1'b0;
    ready1 = 1'b0;
    flush0 = 1'b0;
    rst    = 1'b1;
    #1;
    checkOutput("reset valid0", valid0, 0);
    checkOutput("reset data0", data0, 0);
    checkOutput("reset beat0", beat0, 0);
    checkOutput("reset rd0", rd0, 0);
    checkOutput("reset valid1", valid1, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Continuous drain, standard FIFO.
    @(negedge clk);
    ready0 = 1'b1;
    applyStimulus(0, 1, 16);
    #1;
    checkOutput("t1 rd_en at N", rd0, 1);
    checkOutput("t1 valid at N", valid0, 0);
    exp_v = rd0_count;
    @(negedge clk); #1;
    checkOutput("t1 valid at N+1", valid0, 0);
    @(negedge clk); #1;
    checkOutput("t1 valid at N+2", valid0, 1);
    collect0("t1 data", 1, 16);
    @(negedge clk); #1;
    checkOutput("t1 valid after drain", valid0, 0);
    checkOutput("t1 beat_cnt", beat0, 16);
    checkOutput("t1 rd_en cycles", rd0_count - exp_v, 16);

    // Backpressure with m_ready pattern 1,0,0,1.
    applyStimulus(0, 1, 16);
    exp_v = 1;
    for (int c = 0; c < 100 && exp_v <= 16; c++) begin
      @(negedge clk);
      ready0 = ((c % 4) == 0) || ((c % 4) == 3);
      #1;
      if (valid0) begin
        checkOutput("t2 data", data0, exp_v);
        if (ready0) exp_v++;
      end
    end
    checkOutput("t2 count", exp_v, 17);
    @(negedge clk);
    ready0 = 1'b1;
    #1;
    checkOutput("t2 idle valid", valid0, 0);
    checkOutput("t2 beat_cnt", beat0, 32);

    // Underflow gap.
    applyStimulus(0, 1, 3);
    collect0("t3 first", 1, 3);
    for (int g = 0; g < 5; g++) begin
      @(negedge clk); #1;
      checkOutput("t3 gap valid", valid0, 0);
    end
    applyStimulus(0, 4, 5);
    collect0("t3 second", 4, 5);

    // Flush with a read in flight and one word buffered.
    @(negedge clk);
    ready0 = 1'b0;
    applyStimulus(0, 10, 10);
    @(negedge clk);
    @(negedge clk); #1;
    checkOutput("t4 buffered valid", valid0, 1);
    checkOutput("t4 buffered data", data0, 10);
    applyStimulus(0, 11, 12);
    #1;
    checkOutput("t4 rd before flush", rd0, 1);
    @(negedge clk);
    flush0 = 1'b1;
    #1;
    checkOutput("t4 rd during flush", rd0, 0);
    @(negedge clk);
    flush0 = 1'b0;
    #1;
    checkOutput("t4 valid after flush", valid0, 0);
    checkOutput("t4 beat_cnt kept", beat0, 37);
    ready0 = 1'b1;
    collect0("t4 next word", 12, 12);
    @(negedge clk); #1;
    checkOutput("t4 idle valid", valid0, 0);
    checkOutput("t4 beat_cnt", beat0, 38);

    // Reset mid-stream.
    applyStimulus(0, 1, 10);
    collect0("t5 pre", 1, 5);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5 async valid", valid0, 0);
    checkOutput("t5 async data", data0, 0);
    checkOutput("t5 async beat", beat0, 0);
    checkOutput("t5 rd in reset", rd0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("t5 valid after release", valid0, 0);
    applyStimulus(0, 1, 4);
    collect0("t5 post", 1, 4);
    @(negedge clk); #1;
    checkOutput("t5 beat_cnt", beat0, 4);
    checkOutput("t5 idle valid", valid0, 0);

    // FWFT variant with 4-bit counter and 20 beats.
    @(negedge clk);
    ready1 = 1'b1;
    applyStimulus(1, 1, 20);
    #1;
    checkOutput("t6 rd_en at N", rd1, 1);
    checkOutput("t6 valid at N", valid1, 0);
    @(negedge clk); #1;
    for (int k = 1; k <= 20; k++) begin
      if (k == 17) checkOutput("t6 beat wrap", beat1, 0);
      checkOutput("t6 valid", valid1, 1);
      checkOutput("t6 data", data1, k);
      @(negedge clk);
    end
    #1;
    checkOutput("t6 valid after drain", valid1, 0);
    checkOutput("t6 beat_cnt", beat1, 4);

    checkOutput("no rd_en while empty", viol_empty, 0);
    checkOutput("occupancy bound", viol_occ, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/syncfifo_rd_stream.md
# syncfifo_rd_stream

Read-side adapter for `syncfifo`. It drains the FIFO's `rd_en`/`dout`/`empty` port and presents the words as a valid/ready stream with a 2-entry output buffer. The buffer sustains one word per cycle under continuous `m_ready` and never over-reads. It sits directly on the consumer side of a `syncfifo` instance and supports both standard (1-cycle read latency) and FWFT FIFO configurations.

## Interface
Parameters:
- `DATA_WIDTH`, 8: word width; must match the FIFO's `DATA_WIDTH`.
- `FWFT_EN`, 0: must match the FIFO's setting.
  - 0: `dout` is valid the cycle after `rd_en`.
  - 1: `dout` shows the head word whenever `empty` is low.
- `CNT_WIDTH`, 16: width of the beat counter.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `fifo_dout`  in  DATA_WIDTH: FIFO read data.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_rd_en`  out  1: FIFO read strobe.
- `m_data`  out  DATA_WIDTH: stream data, taken from the head buffer entry.
- `m_valid`  out  1: stream valid, driven from a register.
- `m_ready`  in  1: downstream ready.
- `flush`  in  1: synchronous discard of the buffer and of any in-flight read.
- `beat_cnt`  out  CNT_WIDTH: count of completed stream handshakes.

## Operation
- State:
  - `buf[0:1]` plus `buf_cnt` (0..2), FIFO order, head at `buf[0]`.
  - `inflight`: a read was issued last cycle. Used only when `FWFT_EN=0`.
- A pop occurs in a cycle when `m_valid && m_ready`.
- `fifo_rd_en` is combinational: `!fifo_empty && !flush && (buf_cnt + inflight - pop) < 2`. With `FWFT_EN=1`, `inflight` is always 0.
- Capture:
  - `FWFT_EN=0`: at the edge ending a cycle with `inflight=1`, `fifo_dout` is written to the tail.
  - `FWFT_EN=1`: at the edge ending a cycle with `fifo_rd_en=1`, `fifo_dout` is written to the tail.
- A simultaneous pop and capture shifts `buf[1]` to `buf[0]`, writes the new word to the freed slot, and leaves `buf_cnt` unchanged.
- `m_valid = (buf_cnt != 0)`. `m_data = buf[0]`.
  - `m_data` is held stable while `m_valid && !m_ready`, per AXI-stream rules.
- `beat_cnt` increments on every pop, wraps modulo 2^CNT_WIDTH, and is unaffected by `flush`.
- Flush:
  - In a `flush` cycle, `fifo_rd_en` is 0.
  - A pop in that cycle completes and is counted.
  - At the edge, `buf_cnt` becomes 0.
  - A word returning that cycle (`inflight=1`) is discarded.
  - `inflight` is cleared.
- The buffer never overflows: `buf_cnt + inflight <= 2` at every edge.

## Timing
- Reset values (asynchronous on `rst`): `buf_cnt=0`, `inflight=0`, `buf` all zero, `m_valid=0`, `m_data=0`, `beat_cnt=0`.
  - `fifo_rd_en` is 0 while `rst` is high.
  - A read in flight when reset asserts is lost. The FIFO is reset together with this block.
- Latency from `fifo_empty` falling in cycle N with the block idle:
  - `FWFT_EN=0`: `fifo_rd_en` in N, capture at the end of N+1, `m_valid` in N+2.
  - `FWFT_EN=1`: `fifo_rd_en` in N, `m_valid` in N+1.
- Throughput: one word per cycle while the FIFO is non-empty and `m_ready=1`.
  - Steady state, `FWFT_EN=0`: `buf_cnt=1`, `inflight=1`.
- Backpressure:
  - With `m_ready=0`, reads stop once `buf_cnt + inflight = 2`.
  - Reads resume in the same cycle `m_ready` returns. This is a combinational path from `m_ready` to `fifo_rd_en`.
- FIFO empty mid-stream: `fifo_rd_en` drops in the same cycle. Buffered words still drain. `m_valid` falls the cycle after the last pop.
- `fifo_rd_en` is never asserted while `fifo_empty=1`.

## Test plan
- **Continuous drain, FWFT_EN=0.** Write 1..16 into a 16-deep FIFO, then hold `m_ready=1`.
  - `m_data` = 1..16 on 16 consecutive cycles, first valid 2 cycles after the first `rd_en`.
  - `beat_cnt` = 16.
  - Exactly 16 `rd_en` cycles.
- **Backpressure.** Same FIFO contents, `m_ready` toggling 1,0,0,1 repeating.
  - Order is preserved and `m_data` stays stable while stalled.
  - `buf_cnt + inflight` never exceeds 2.
  - No `rd_en` while empty.
- **Underflow gap.** Write 1..3, drain, wait 5 cycles, write 4..5.
  - Output is 1..5 in order.
  - `m_valid` is low during the gap.
  - No `rd_en` while `fifo_empty=1`.
- **Flush with a read in flight.** Assert `flush` the cycle after a `rd_en`, with `buf_cnt=1`.
  - Both the buffered and the returning words are discarded.
  - The next output is the following FIFO word.
  - `beat_cnt` is unchanged by the flush.
- **Reset mid-stream.** Assert `rst` after 5 beats.
  - `m_valid`, `m_data`, and `beat_cnt` go to 0 immediately, without waiting for a clock edge.
  - After release and a FIFO refill of 1..4, the output is 1..4.
- **FWFT_EN=1 variant.** Repeat the continuous-drain test.
  - First `m_valid` appears 1 cycle after the first `rd_en`.
  - One word per cycle, values 1..16.
  - `beat_cnt` wraps correctly when run with `CNT_WIDTH=4` and 20 beats (ends at 4).
